// File: rtl/pcs_tx_pkg.sv
// Shared constants and types for the 64b/66b transmit block path.
package pcs_tx_pkg;

    localparam int DW = 66;
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;
    localparam logic [DW-1:0] IDLE_BLK = {2'b10, 64'h000000000000001e};

    typedef enum logic {
        ARB = 1'b0,
        PKT = 1'b1
    } fsm_t;

endpackage

// File: rtl/tx_oreg.sv
// Output register towards the gearbox sequencer: loads when empty or draining, holds under pause.
module tx_oreg #(
    parameter int DW = 66
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_vld,
    input  logic [DW-1:0] load_dat,
    input  logic          rdy_i,
    output logic          load_en,
    output logic [DW-1:0] dat_o,
    output logic          vld_o
);

    assign load_en = !vld_o || rdy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_o <= 1'b0;
            dat_o <= '0;
        end else if (load_en) begin
            vld_o <= load_vld;
            if (load_vld) begin
                dat_o <= load_dat;
            end
        end
    end

endmodule

// File: rtl/tx_blk_sched.sv
// Arbitrates packet data and control blocks onto the gearbox input, keeping packets whole,
// enforcing an inter-packet gap and bounding control bursts while data waits.
module tx_blk_sched #(
    parameter int DW             = 66,
    parameter int MIN_IPG        = 1,
    parameter int CTRL_MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] d_dat,
    input  logic          d_sop,
    input  logic          d_eop,
    input  logic          d_vld,
    output logic          d_rdy,
    input  logic [DW-1:0] c_dat,
    input  logic          c_vld,
    output logic          c_rdy,
    output logic [DW-1:0] dat_o,
    output logic          vld_o,
    input  logic          rdy_i,
    output logic          in_pkt,
    output logic          err_underrun,
    output logic          err_proto
);
    import pcs_tx_pkg::*;

    localparam logic [3:0] IPG_LOAD  = 4'(MIN_IPG);
    localparam logic [3:0] BURST_MAX = 4'(CTRL_MAX_BURST);

    fsm_t          state;
    logic [3:0]    ipg_cnt;
    logic [3:0]    burst_cnt;
    logic          load_en;
    logic          grant_c;
    logic          grant_d;
    logic          discard;
    logic          load_vld;
    logic          eop_done;
    logic [DW-1:0] load_dat;

    always_comb begin
        grant_c = 1'b0;
        grant_d = 1'b0;
        if (rst_n) begin
            if (state == ARB) begin
                if (ipg_cnt == 4'd0) begin
                    if (c_vld && (!d_vld || burst_cnt < BURST_MAX)) begin
                        grant_c = 1'b1;
                    end else if (d_vld) begin
                        grant_d = 1'b1;
                    end
                end
            end else begin
                grant_d = d_vld;
            end
        end
    end

    assign d_rdy = load_en && grant_d;
    assign c_rdy = load_en && grant_c;

    // A headless beat outside a packet is consumed but never reaches the gearbox.
    assign discard      = d_rdy && (state == ARB) && !d_sop;
    assign load_vld     = c_rdy || (d_rdy && !discard);
    assign load_dat     = c_rdy ? c_dat : d_dat;
    assign err_proto    = d_rdy && ((state == ARB) ? !d_sop : d_sop);
    assign err_underrun = rst_n && (state == PKT) && load_en && !d_vld;
    assign eop_done     = d_rdy && d_eop && ((state == PKT) || d_sop);
    assign in_pkt       = (state == PKT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            ipg_cnt   <= 4'd0;
            burst_cnt <= 4'd0;
        end else begin
            case (state)
                ARB: if (d_rdy && d_sop && !d_eop) state <= PKT;
                PKT: if (d_rdy && d_eop) state <= ARB;
                default: state <= ARB;
            endcase

            // Every unpaused slot while the gap is armed loads one idle, so exactly
            // MIN_IPG idle slots reach the gearbox between EOP and the next block.
            if (eop_done) begin
                ipg_cnt <= IPG_LOAD;
            end else if (rdy_i && ipg_cnt != 4'd0) begin
                ipg_cnt <= ipg_cnt - 4'd1;
            end

            if (d_rdy && d_sop) begin
                burst_cnt <= 4'd0;
            end else if (state == ARB && !c_vld) begin
                burst_cnt <= 4'd0;
            end else if (c_rdy && burst_cnt < BURST_MAX) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end
    end

    tx_oreg #(
        .DW(DW)
    ) u_oreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_vld (load_vld),
        .load_dat (load_dat),
        .rdy_i    (rdy_i),
        .load_en  (load_en),
        .dat_o    (dat_o),
        .vld_o    (vld_o)
    );

endmodule

// File: tb/tb_tx_blk_sched.sv
// Self-checking bench for tx_blk_sched: vector table plus scoreboarded multi-cycle sequences.
module tb_tx_blk_sched;
    localparam int DW = 66;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] d_dat = '0;
    logic          d_sop = 1'b0;
    logic          d_eop = 1'b0;
    logic          d_vld = 1'b0;
    logic          d_rdy;
    logic [DW-1:0] c_dat = '0;
    logic          c_vld = 1'b0;
    logic          c_rdy;
    logic [DW-1:0] dat_o;
    logic          vld_o;
    logic          rdy_i = 1'b1;
    logic          in_pkt;
    logic          err_underrun;
    logic          err_proto;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] sb_exp;
    bit            log_en = 1'b0;
    logic [31:0]   pat = '0;
    int            npat = 0;
    int            viol = 0;

    tx_blk_sched #(.DW(DW), .MIN_IPG(1), .CTRL_MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_dat(d_dat), .d_sop(d_sop), .d_eop(d_eop), .d_vld(d_vld), .d_rdy(d_rdy),
        .c_dat(c_dat), .c_vld(c_vld), .c_rdy(c_rdy),
        .dat_o(dat_o), .vld_o(vld_o), .rdy_i(rdy_i),
        .in_pkt(in_pkt), .err_underrun(err_underrun), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every downstream transfer must match the oldest expected block.
    always @(negedge clk) begin
        if (rst_n && vld_o && rdy_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got %0h want no block", dat_o);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_dat", dat_o, sb_exp);
            end
        end
    end

    always @(negedge clk) begin
        if (log_en) begin
            if (c_vld && c_rdy) begin pat = {pat[30:0], 1'b1}; npat++; end
            if (d_vld && d_rdy) begin pat = {pat[30:0], 1'b0}; npat++; end
            if (in_pkt && c_rdy) viol++;
        end
    end

    task automatic send_d(input logic [DW-1:0] dat, input logic sop, input logic eop, input logic fwd);
        bit ok;
        ok = 1'b0;
        d_dat = dat; d_sop = sop; d_eop = eop; d_vld = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (d_rdy) begin
                ok = 1'b1;
                if (fwd) exp_q.push_back(dat);
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL d_accept_timeout: got d_rdy=0 want d_rdy=1");
        end
    endtask

    task automatic send_c(input logic [DW-1:0] dat);
        bit ok;
        ok = 1'b0;
        c_dat = dat; c_vld = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (c_rdy) begin
                ok = 1'b1;
                exp_q.push_back(dat);
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL c_accept_timeout: got c_rdy=0 want c_rdy=1");
        end
    endtask

    task automatic send_pkt(input logic [63:0] base, input int n);
        for (int b = 0; b < n; b++) begin
            send_d({2'b01, base + 64'(b)}, b == 0, b == n - 1, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       c_vld;
        logic       d_vld;
        logic       sop;
        logic       eop;
        logic [4:0] exp_o;  // {c_rdy, d_rdy, err_proto, err_underrun, in_pkt}
        logic       exp_v;  // vld_o on the following cycle
    } vec_t;

    vec_t          tv[11];
    logic [6:0]    seq;
    logic [DW-1:0] b2;
    bit            found;
    int            eu;

    initial begin
        tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b10000, 1'b1};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b01100, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 5'b01000, 1'b1};
        tv[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b00000, 1'b0};
        tv[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b10000, 1'b1};
        tv[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b01000, 1'b1};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00011, 1'b0};
        tv[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b01101, 1'b1};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'b01001, 1'b1};
        tv[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_out", {dat_o, vld_o, d_rdy, c_rdy, in_pkt, err_underrun, err_proto}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single-cycle arbitration/framing vectors from a clean post-reset state
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            c_vld = tv[i].c_vld; d_vld = tv[i].d_vld; d_sop = tv[i].sop; d_eop = tv[i].eop;
            c_dat = {2'b10, 64'hC000 + 64'(i)};
            d_dat = {2'b01, 64'hD000 + 64'(i)};
            @(negedge clk);
            if (i > 0) chk($sformatf("vec%0d_vld", i - 1), vld_o, tv[i - 1].exp_v);
            chk($sformatf("vec%0d_out", i), {c_rdy, d_rdy, err_proto, err_underrun, in_pkt}, tv[i].exp_o);
            if (tv[i].exp_v) exp_q.push_back(tv[i].exp_o[4] ? c_dat : d_dat);
        end
        @(posedge clk); #1;
        c_vld = 0; d_vld = 0; d_sop = 0; d_eop = 0;
        @(negedge clk);
        chk("vec10_vld", vld_o, tv[10].exp_v);
        idle(4);

        // Two back-to-back packets: exactly one idle slot between them
        found = 1'b0;
        fork
            begin
                send_pkt(64'h1000, 3);
                send_pkt(64'h2000, 3);
                d_vld = 1'b0;
            end
            begin
                for (int k = 0; k < 100 && !found; k++) begin
                    @(negedge clk);
                    if (vld_o) found = 1'b1;
                end
                seq[6] = vld_o;
                for (int j = 5; j >= 0; j--) begin
                    @(negedge clk);
                    seq[j] = vld_o;
                end
            end
        join
        chk("ipg_start", found, 1'b1);
        chk("ipg_pattern", seq, 7'b1110111);
        idle(4);

        // Gearbox pause while the second beat is on dat_o
        found = 1'b0;
        b2 = {2'b01, 64'h3001};
        fork
            begin
                send_pkt(64'h3000, 3);
                d_vld = 1'b0;
            end
            begin
                for (int k = 0; k < 100 && !found; k++) begin
                    @(posedge clk); #1;
                    if (vld_o && dat_o == b2) begin
                        found = 1'b1;
                        rdy_i = 1'b0;
                    end
                end
                if (found) begin
                    @(negedge clk);
                    chk("hold_d_rdy", d_rdy, 1'b0);
                    chk("hold_vld0", vld_o, 1'b1);
                    @(posedge clk); #1;
                    rdy_i = 1'b1;
                    @(negedge clk);
                    chk("hold_dat", dat_o, b2);
                    chk("hold_vld1", vld_o, 1'b1);
                end
            end
        join
        chk("hold_seen", found, 1'b1);
        idle(4);

        // Control and data both pending: bounded control bursts around whole packets
        log_en = 1'b1;
        fork
            begin
                for (int n = 0; n < 8; n++) send_c({2'b10, 64'h4000 + 64'(n)});
                c_vld = 1'b0;
            end
            begin
                send_pkt(64'h5000, 3);
                send_pkt(64'h6000, 3);
                d_vld = 1'b0;
            end
        join
        log_en = 1'b0;
        chk("burst_n", npat, 14);
        chk("burst_pat", pat[13:0], 14'b11110001111000);
        chk("burst_c_in_pkt", viol, 0);
        idle(4);

        // Source stalls two slots mid-packet
        eu = 0;
        send_d({2'b01, 64'h7000}, 1'b1, 1'b0, 1'b1);
        send_d({2'b01, 64'h7001}, 1'b0, 1'b0, 1'b1);
        d_vld = 1'b0;
        @(negedge clk);
        eu += int'(err_underrun);
        chk("ur_in_pkt0", in_pkt, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        eu += int'(err_underrun);
        chk("ur_in_pkt1", in_pkt, 1'b1);
        chk("ur_idle0", vld_o, 1'b0);
        @(posedge clk); #1;
        d_dat = {2'b01, 64'h7002}; d_sop = 1'b0; d_eop = 1'b1; d_vld = 1'b1;
        @(negedge clk);
        eu += int'(err_underrun);
        chk("ur_idle1", vld_o, 1'b0);
        chk("ur_eop_rdy", d_rdy, 1'b1);
        if (d_rdy) exp_q.push_back(d_dat);
        @(posedge clk); #1;
        d_vld = 1'b0; d_eop = 1'b0;
        chk("ur_count", eu, 2);
        idle(4);

        // Asynchronous reset in the middle of a packet
        send_d({2'b01, 64'h8000}, 1'b1, 1'b0, 1'b1);
        send_d({2'b01, 64'h8001}, 1'b0, 1'b0, 1'b1);
        d_vld = 1'b0;
        chk("rst_pre_vld", vld_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {dat_o, vld_o, in_pkt}, '0);
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        d_dat = {2'b01, 64'h9000}; d_sop = 1'b0; d_eop = 1'b0; d_vld = 1'b1;
        @(negedge clk);
        chk("post_rst_nosop", {d_rdy, err_proto}, 2'b11);
        @(posedge clk); #1;
        d_vld = 1'b0;
        @(negedge clk);
        chk("post_rst_discard", {vld_o, in_pkt}, 2'b00);
        @(posedge clk); #1;
        send_d({2'b01, 64'h9100}, 1'b1, 1'b1, 1'b1);
        d_vld = 1'b0; d_sop = 1'b0; d_eop = 1'b0;
        idle(6);
        chk("sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
